// File: rtl/instr_fetch_rv32i.sv
// rtl/instr_fetch_rv32i.sv - RV32I instruction fetch unit: req/gnt memory side, valid/ready decode side, redirects
module instr_fetch_rv32i #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clock,
   input  logic        nreset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misaligned_err
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        discard_q, discard_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        redirect_ok;

   assign redirect_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         discard_q    <= 1'b0;
         instr_q      <= 32'h00000000;
         ipc_q        <= 32'h00000000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         discard_q    <= discard_d;
         instr_q      <= instr_d;
         ipc_q        <= ipc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      discard_d    = discard_q;
      instr_d      = instr_q;
      ipc_d        = ipc_q;
      case (state_q)
         ST_REQ: begin
            if (redirect_ok) begin
               pc_d = redirect_pc;
               // A grant coinciding with a redirect fetches a stale address; drop its response.
               if (imem_gnt) begin
                  state_d   = ST_WAIT;
                  discard_d = 1'b1;
               end
            end else if (imem_gnt) begin
               state_d      = ST_WAIT;
               fetch_addr_d = pc_q;
               pc_d         = pc_q + 32'd4;
               discard_d    = 1'b0;
            end
         end
         ST_WAIT: begin
            if (redirect_ok) begin
               pc_d = redirect_pc;
               if (imem_rvalid) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  instr_d = imem_rdata;
                  ipc_d   = fetch_addr_q;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_ok) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end else if (id_ready) begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   assign imem_req       = (state_q == ST_REQ);
   assign imem_addr      = pc_q;
   assign if_valid       = (state_q == ST_HOLD);
   assign if_instr       = instr_q;
   assign if_pc          = ipc_q;
   assign misaligned_err = nreset && redirect_valid && (redirect_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_instr_fetch_rv32i.sv
// tb/tb_instr_fetch_rv32i.sv - randomized scoreboard bench for instr_fetch_rv32i
module tb_instr_fetch_rv32i;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        nreset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misaligned_err;

   logic        w_nreset;
   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic        w_imem_gnt;
   logic        w_imem_rvalid;
   logic [31:0] w_imem_rdata;
   logic        w_if_valid;
   logic [31:0] w_if_instr;
   logic [31:0] w_if_pc;
   logic        w_id_ready;
   logic        w_misaligned_err;

   instr_fetch_rv32i u_dut (
      .clock(clock), .nreset(nreset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .misaligned_err(misaligned_err)
   );

   instr_fetch_rv32i #(.RESET_PC(32'hFFFFFFFC)) u_dut_wrap (
      .clock(clock), .nreset(w_nreset),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_imem_gnt),
      .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
      .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .id_ready(w_id_ready),
      .redirect_valid(1'b0), .redirect_pc(32'h00000000),
      .misaligned_err(w_misaligned_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Instruction memory contents as a pure function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h00000013;
   endfunction

   // Transaction-level reference: next fetch address, one outstanding fetch, one held instruction.
   logic [31:0] m_pc;
   logic        m_pending;
   logic        m_wanted;
   logic [31:0] m_paddr;
   logic        m_held;
   logic [63:0] exp_q[$];

   task automatic model_reset();
      m_pc      = 32'h00000000;
      m_pending = 1'b0;
      m_wanted  = 1'b0;
      m_paddr   = 32'h00000000;
      m_held    = 1'b0;
      exp_q.delete();
   endtask

   // Drive one cycle of stimulus at the falling edge, check, then advance the model.
   task automatic step(input logic gnt, input logic rv, input logic rd,
                       input logic redir, input logic [31:0] rpc);
      logic req_phase;
      logic redir_ok;
      imem_gnt       = gnt;
      imem_rvalid    = rv;
      imem_rdata     = (rv && m_pending) ? mem_word(m_paddr) : $urandom;
      id_ready       = rd;
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
      req_phase = !m_pending && !m_held;
      redir_ok  = redir && (rpc[1:0] == 2'b00);
      check("imem_req", {31'd0, imem_req}, {31'd0, req_phase});
      if (req_phase) check("imem_addr", imem_addr, m_pc);
      check("if_valid", {31'd0, if_valid}, {31'd0, m_held});
      check("misaligned_err", {31'd0, misaligned_err}, {31'd0, redir && !redir_ok});
      if (req_phase) begin
         if (redir_ok) begin
            if (gnt) begin
               m_pending = 1'b1;
               m_wanted  = 1'b0;
            end
            m_pc = rpc;
         end else if (gnt) begin
            m_pending = 1'b1;
            m_wanted  = 1'b1;
            m_paddr   = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end else if (m_pending) begin
         if (redir_ok) begin
            m_pc = rpc;
            if (rv) m_pending = 1'b0;
            else    m_wanted  = 1'b0;
         end else if (rv) begin
            m_pending = 1'b0;
            if (m_wanted) begin
               m_held = 1'b1;
               exp_q.push_back({m_paddr, mem_word(m_paddr)});
            end
         end
      end else begin
         if (redir_ok) begin
            m_held = 1'b0;
            m_pc   = rpc;
         end else if (rd) begin
            m_held = 1'b0;
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   // Monitor: each new presentation on the decode side must match the oldest expected fetch.
   logic        prev_valid = 1'b0;
   logic [63:0] cur = 64'd0;
   always @(negedge clock) begin
      if (nreset && if_valid) begin
         if (!prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_if_valid actual_pc=%h required=no_instruction", if_pc);
            end else begin
               cur = exp_q.pop_front();
               check("if_pc", if_pc, cur[63:32]);
               check("if_instr", if_instr, cur[31:0]);
            end
         end else begin
            check("if_pc_stable", if_pc, cur[63:32]);
            check("if_instr_stable", if_instr, cur[31:0]);
         end
      end
      prev_valid = nreset && if_valid;
   end

   initial begin
      logic [31:0] held_addr;
      logic [31:0] rnd;
      nreset         = 1'b0;
      w_nreset       = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h00000002;
      w_imem_gnt     = 1'b0;
      w_imem_rvalid  = 1'b0;
      w_imem_rdata   = 32'h0;
      w_id_ready     = 1'b0;
      model_reset();

      @(negedge clock);
      #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd1);
      check("rst_imem_addr", imem_addr, 32'h00000000);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_misaligned_err", {31'd0, misaligned_err}, 32'd0);
      check("rst_wrap_addr", w_imem_addr, 32'hFFFFFFFC);
      redirect_valid = 1'b0;
      @(negedge clock);
      nreset   = 1'b1;
      w_nreset = 1'b1;

      // Fetch from the last word of the address space wraps the PC to zero.
      w_imem_gnt = 1'b1;
      @(negedge clock);
      w_imem_gnt    = 1'b0;
      w_imem_rvalid = 1'b1;
      w_imem_rdata  = 32'hCAFE0013;
      @(negedge clock);
      w_imem_rvalid = 1'b0;
      check("wrap_if_valid", {31'd0, w_if_valid}, 32'd1);
      check("wrap_if_pc", w_if_pc, 32'hFFFFFFFC);
      check("wrap_if_instr", w_if_instr, 32'hCAFE0013);
      w_id_ready = 1'b1;
      @(negedge clock);
      w_id_ready = 1'b0;
      check("wrap_imem_req", {31'd0, w_imem_req}, 32'd1);
      check("wrap_imem_addr", w_imem_addr, 32'h00000000);

      // Minimum-latency fetch from address 0.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("next_addr_after_first", imem_addr, 32'h00000004);

      // Grant stall then decode stall.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      // Redirect while waiting drops the response.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h00000100);
      step(0, 1, 0, 0, 0);
      check("redirect_wait_no_valid", {31'd0, if_valid}, 32'd0);
      check("redirect_wait_addr", imem_addr, 32'h00000100);

      // Misaligned redirect is ignored.
      step(0, 0, 0, 1, 32'h00000102);
      check("misaligned_addr_kept", imem_addr, 32'h00000100);

      // Redirect coinciding with grant, and redirect while holding with id_ready.
      step(1, 0, 0, 1, 32'h00000200);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 32'h00000300);
      check("redirect_hold_addr", imem_addr, 32'h00000300);

      // Asynchronous reset while waiting, then a stale response.
      step(1, 0, 0, 0, 0);
      held_addr = 32'h0;
      nreset = 1'b0;
      #1;
      check("async_rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("async_rst_addr", imem_addr, held_addr);
      check("async_rst_req", {31'd0, imem_req}, 32'd1);
      model_reset();
      @(negedge clock);
      nreset = 1'b1;
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rnd = $urandom;
         step(rnd[1:0] != 2'b00, rnd[3:2] != 2'b00, rnd[5:4] != 2'b00,
              rnd[9:6] == 4'd0,
              (rnd[10] ? {16'd0, $urandom_range(0, 16'hFFFF)} : $urandom) & {30'h3FFFFFFF, rnd[12:11]});
      end

      if (exp_q.size() > 1) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required<=1", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_rv32i.md
INSTR_FETCH_RV32I -- requirements
Module: instr_fetch_rv32i

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 Port clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port nreset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-005 Port imem_addr  output  32  SHALL be the fetch address, always word-aligned.
REQ-006 Port imem_gnt  input  1  SHALL be memory acceptance of the request.
REQ-007 Port imem_rvalid  input  1  SHALL mark imem_rdata as valid.
REQ-008 Port imem_rdata  input  32  SHALL be the returned instruction word.
REQ-009 Port if_valid  output  1  SHALL mark if_instr and if_pc as valid for decode.
REQ-010 Port if_instr  output  32  SHALL be the fetched instruction.
REQ-011 Port if_pc  output  32  SHALL be the address if_instr was fetched from.
REQ-012 Port id_ready  input  1  SHALL be decode acceptance; transfer occurs when if_valid and id_ready are both 1.
REQ-013 Port redirect_valid  input  1  SHALL request a PC change (branch/jump).
REQ-014 Port redirect_pc  input  32  SHALL be the redirect target.
REQ-015 Port misaligned_err  output  1  SHALL pulse on a rejected redirect.

Function
REQ-016 FSM states SHALL be REQ, WAIT and HOLD, plus an internal PC register and a discard flag.
REQ-017 REQ: imem_req=1, imem_addr=PC; on imem_gnt -> WAIT, fetch address latched, PC <= PC+4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-018 imem_addr SHALL stay constant while imem_req=1 and imem_gnt=0, except when an accepted redirect changes it.
REQ-019 WAIT: imem_req=0; on imem_rvalid with discard=0, if_instr <= imem_rdata, if_pc <= latched fetch address, -> HOLD.
REQ-020 HOLD: if_valid=1, if_instr/if_pc held stable; on id_ready=1 -> REQ next cycle.
REQ-021 if_valid SHALL be 1 only in HOLD; imem_rvalid SHALL be ignored outside WAIT.
REQ-022 Minimum latency: grant at cycle N, rvalid at N+1, if_valid at N+2.
REQ-023 Redirect (redirect_valid=1, redirect_pc[1:0]=2'b00) SHALL take priority over all other transitions: PC <= redirect_pc.
REQ-024 Redirect in REQ without imem_gnt: stay REQ; imem_addr=redirect_pc from next cycle.
REQ-025 Redirect in REQ with imem_gnt in the same cycle: -> WAIT with discard=1.
REQ-026 Redirect in WAIT: discard <= 1; a response arriving in the same or a later cycle SHALL be dropped, discard cleared, -> REQ.
REQ-027 Redirect in HOLD: if_valid=0 from next cycle, -> REQ; with id_ready=1 in that cycle the held instruction counts as transferred.
REQ-028 Redirect with redirect_pc[1:0]!=0 SHALL be ignored entirely; misaligned_err=1 for exactly that cycle.

Reset
REQ-029 nreset=0 SHALL immediately force state REQ, PC=RESET_PC, discard=0, if_valid=0, if_instr=0, if_pc=0, misaligned_err=0, at any point including mid-transaction.
REQ-030 Outputs are combinational from the state: during reset imem_req=1 and imem_addr=RESET_PC, with no fetch accepted until nreset=1.

Verification
REQ-031 Reset release, imem_gnt=1 and rvalid with rdata=32'h00000013 the next cycle, id_ready=1 -> if_pc=0, if_instr=32'h00000013; next imem_addr=32'h00000004.
REQ-032 Hold imem_gnt=0 for 3 cycles -> imem_req=1 and imem_addr constant; hold id_ready=0 for 3 cycles -> if_valid=1 and if_instr stable.
REQ-033 RESET_PC=32'hFFFFFFFC; fetch completes -> if_pc=32'hFFFFFFFC, next imem_addr=32'h00000000.
REQ-034 Redirect to 32'h00000100 while in WAIT, then rvalid -> no if_valid; next imem_addr=32'h00000100.
REQ-035 Redirect to 32'h00000102 -> misaligned_err=1 for one cycle, PC and state unchanged.
REQ-036 nreset asserted in WAIT -> if_valid=0, imem_addr=RESET_PC immediately; a stale rvalid after release is ignored.
